// File: rtl/auto_crc_chk.sv
// auto_crc_chk: bit-serial CRC checker (payload + appended CRC field), ICB-configured. Rev 1.0
`default_nettype none

module auto_crc_chk (
  input  logic        clk,
  input  logic        rst_,
  input  logic        icb_wr,
  input  logic [7:0]  icb_wadr,
  input  logic [31:0] icb_wdat,
  output logic        icb_wack,
  input  logic        icb_rd,
  input  logic [7:0]  icb_radr,
  output logic [31:0] icb_rdat,
  output logic        icb_rack,
  input  logic        sof_i,
  input  logic        data_vld_i,
  input  logic        data_i,
  output logic        data_o,
  output logic        data_vld_o,
  output logic        irq
);

  localparam logic [7:0] ADDR_CON    = 8'd0;
  localparam logic [7:0] ADDR_POLY   = 8'd1;
  localparam logic [7:0] ADDR_INIT   = 8'd2;
  localparam logic [7:0] ADDR_PLEN   = 8'd3;
  localparam logic [7:0] ADDR_STAT   = 8'd4;
  localparam logic [7:0] ADDR_RESULT = 8'd5;
  localparam logic [7:0] ADDR_RXCRC  = 8'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      3'd1:    len_mask = 32'h0000_00FF;
      3'd2:    len_mask = 32'h0000_FFFF;
      3'd3:    len_mask = 32'h00FF_FFFF;
      default: len_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic msb_of(input logic [31:0] v, input logic [2:0] len);
    case (len)
      3'd1:    msb_of = v[7];
      3'd2:    msb_of = v[15];
      3'd3:    msb_of = v[23];
      default: msb_of = v[31];
    endcase
  endfunction

  // configuration / status registers
  logic        con_en;
  logic [2:0]  con_len;
  logic        con_irq_en;
  logic [31:0] poly;
  logic [31:0] init;
  logic [15:0] plen;
  logic        stat_done;
  logic        stat_ok;
  logic        stat_err;
  logic [31:0] result;
  logic [31:0] rxcrc_reg;

  // per-frame shadows and datapath
  state_t      state;
  state_t      state_nx;
  logic [2:0]  sh_len;
  logic [31:0] sh_poly;
  logic [15:0] sh_plen;
  logic [31:0] lfsr;
  logic [31:0] lfsr_nx;
  logic [31:0] rxcrc;
  logic [31:0] rx_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic        fwd;

  logic        wr_con;
  logic        wr_poly;
  logic        wr_init;
  logic        wr_plen;
  logic        wr_stat;
  logic        len_ok;
  logic        busy;
  logic        sof_hit;
  logic        start;
  logic        err_set;
  logic        step_bit;
  logic        done_set;

  logic [2:0]  f_len;
  logic [31:0] f_poly;
  logic [15:0] f_plen;
  logic [31:0] f_mask;
  logic [15:0] f_n;
  state_t      eff_state;
  logic [31:0] base_lfsr;
  logic [31:0] base_rx;
  logic [15:0] base_cnt;
  logic [15:0] cnt_inc;
  logic        fb;
  logic [31:0] step_lfsr;
  logic [31:0] step_rx;

  assign icb_wack = icb_wr;
  assign icb_rack = icb_rd;

  assign wr_con  = icb_wr && (icb_wadr == ADDR_CON);
  assign wr_poly = icb_wr && (icb_wadr == ADDR_POLY);
  assign wr_init = icb_wr && (icb_wadr == ADDR_INIT);
  assign wr_plen = icb_wr && (icb_wadr == ADDR_PLEN);
  assign wr_stat = icb_wr && (icb_wadr == ADDR_STAT);

  assign len_ok   = (con_len != 3'd0) && (con_len <= 3'd4);
  assign busy     = (state == ST_PAY) || (state == ST_CHK);
  assign sof_hit  = con_en && sof_i && data_vld_i;
  assign start    = sof_hit && len_ok;
  assign err_set  = sof_hit && (!len_ok || busy);
  assign step_bit = start || (con_en && data_vld_i && !sof_i && busy);
  assign done_set = (state == ST_DONE);

  // A sof bit is processed in the same cycle it starts the frame, so the
  // frame context comes from the live registers on that cycle only.
  assign f_len     = start ? con_len : sh_len;
  assign f_poly    = start ? poly    : sh_poly;
  assign f_plen    = start ? plen    : sh_plen;
  assign f_mask    = len_mask(f_len);
  assign f_n       = {10'd0, f_len, 3'd0};
  assign eff_state = start ? ((plen == 16'd0) ? ST_CHK : ST_PAY) : state;
  assign base_lfsr = start ? (init & f_mask) : lfsr;
  assign base_rx   = start ? 32'd0 : rxcrc;
  assign base_cnt  = start ? 16'd0 : cnt;
  assign cnt_inc   = base_cnt + 16'd1;
  assign fb        = data_i ^ msb_of(base_lfsr, f_len);
  assign step_lfsr = ({base_lfsr[30:0], 1'b0} ^ (fb ? f_poly : 32'd0)) & f_mask;
  assign step_rx   = {base_rx[30:0], data_i} & f_mask;

  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    rx_nx    = rxcrc;
    cnt_nx   = cnt;
    fwd      = 1'b0;
    if (step_bit) begin
      lfsr_nx  = base_lfsr;
      rx_nx    = base_rx;
      state_nx = eff_state;
      if (eff_state == ST_PAY) begin
        lfsr_nx = step_lfsr;
        fwd     = 1'b1;
        if (cnt_inc == f_plen) begin
          state_nx = ST_CHK;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx   = cnt_inc;
        end
      end else begin
        rx_nx = step_rx;
        if (cnt_inc == f_n) begin
          state_nx = ST_DONE;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx   = cnt_inc;
        end
      end
    end else begin
      case (state)
        ST_DONE: state_nx = ST_IDLE;
        ST_PAY, ST_CHK: begin
          if (!con_en || sof_hit) state_nx = ST_IDLE;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state      <= ST_IDLE;
      con_en     <= 1'b0;
      con_len    <= 3'd0;
      con_irq_en <= 1'b0;
      poly       <= 32'd0;
      init       <= 32'd0;
      plen       <= 16'd0;
      stat_done  <= 1'b0;
      stat_ok    <= 1'b0;
      stat_err   <= 1'b0;
      result     <= 32'd0;
      rxcrc_reg  <= 32'd0;
      sh_len     <= 3'd0;
      sh_poly    <= 32'd0;
      sh_plen    <= 16'd0;
      lfsr       <= 32'd0;
      rxcrc      <= 32'd0;
      cnt        <= 16'd0;
      data_o     <= 1'b0;
      data_vld_o <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      rxcrc <= rx_nx;
      cnt   <= cnt_nx;

      if (wr_con) begin
        con_en     <= icb_wdat[0];
        con_len    <= icb_wdat[3:1];
        con_irq_en <= icb_wdat[5];
      end
      if (wr_poly) poly <= icb_wdat;
      if (wr_init) init <= icb_wdat;
      if (wr_plen) plen <= icb_wdat[15:0];

      if (start) begin
        sh_len  <= con_len;
        sh_poly <= poly;
        sh_plen <= plen;
      end

      // hardware set has priority over a same-cycle W1C clear
      stat_done <= (stat_done && !(wr_stat && icb_wdat[0])) || done_set;
      stat_err  <= (stat_err  && !(wr_stat && icb_wdat[2])) || err_set;
      if (done_set) begin
        stat_ok   <= (lfsr == rxcrc);
        result    <= lfsr;
        rxcrc_reg <= rxcrc;
      end else if (wr_stat && icb_wdat[1]) begin
        stat_ok   <= 1'b0;
      end

      data_vld_o <= fwd;
      data_o     <= fwd ? data_i : 1'b0;
    end
  end

  always_comb begin
    icb_rdat = 32'd0;
    case (icb_radr)
      ADDR_CON:    icb_rdat = {26'd0, con_irq_en, 1'b0, con_len, con_en};
      ADDR_POLY:   icb_rdat = poly;
      ADDR_INIT:   icb_rdat = init;
      ADDR_PLEN:   icb_rdat = {16'd0, plen};
      ADDR_STAT:   icb_rdat = {29'd0, stat_err, stat_ok, stat_done};
      ADDR_RESULT: icb_rdat = result;
      ADDR_RXCRC:  icb_rdat = rxcrc_reg;
      default:     icb_rdat = 32'd0;
    endcase
  end

  assign irq = (stat_done && con_irq_en) || (stat_err && con_irq_en);

endmodule

`default_nettype wire
